enc_sweep_checker: RTL and testbench
====================================

ENC_SWEEP_CHECKER -- requirements
Module: enc_sweep_checker

Interface
REQ-001 SHALL have parameter IN_W, default 10, width of the encoder input word under test.
REQ-002 SHALL have parameter OUT_W, default 4, width of the encoder output.
REQ-003 SHALL have parameter SWEEP_LEN, default 1024, number of samples per sweep.
REQ-004 SHALL have parameter TRIG_MASK, default 'hF, and TRIG_VAL, default 'hB, which select the in_data bits and value for trigger detection.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, a one-cycle pulse that begins a sweep.
REQ-009 SHALL have port in_vld, input, 1, which qualifies in_data and enc_out.
REQ-010 SHALL have port in_data, input, IN_W, the word applied to the upstream encoder.
REQ-011 SHALL have port enc_out, input, OUT_W, the encoder result for in_data.
REQ-012 SHALL have port busy, output, 1, high while a sweep is running.
REQ-013 SHALL have port done, output, 1, high while sweep results are held.
REQ-014 SHALL have port match_cnt, output, IN_W+1, count of samples that matched.
REQ-015 SHALL have port mism_cnt, output, IN_W+1, count of samples that mismatched.
REQ-016 SHALL have port alarm, output, 1, sticky flag for any mismatch.
REQ-017 SHALL have port first_bad_addr, output, IN_W, in_data of the first mismatch.
REQ-018 SHALL have port first_bad_val, output, OUT_W, enc_out of the first mismatch.
REQ-019 SHALL have port trig_hit, output, 1, sticky flag for a trigger-pattern mismatch (see Configuration).

Function
REQ-020 SHALL compute golden(in_data) as the index of the most-significant set bit, i.e. floor(log2(in_data)); in_data=1 gives 0 and in_data=512 gives 9.
REQ-021 SHALL treat in_data=0 as don't-care: the sample counts as a match whatever enc_out is.
REQ-022 SHALL implement FSM states IDLE, RUN and DONE.
REQ-023 SHALL transition IDLE->RUN on start, clearing counters, alarm, first_bad_* and trig_hit in the same edge.
REQ-024 SHALL, in RUN, sample on every edge where in_vld=1; samples with in_vld=0 are ignored.
REQ-025 SHALL have registered outputs: counters and flags reflect a sample one cycle after it is sampled.
REQ-026 SHALL move to DONE on the edge that takes the SWEEP_LEN-th sample; done is then high and busy low from the next cycle.
REQ-027 SHALL hold all results in DONE; start in DONE behaves as start in IDLE (re-arm).
REQ-028 SHALL ignore start while in RUN.
REQ-029 SHALL capture first_bad_addr and first_bad_val only on the first mismatch of a sweep; later mismatches do not overwrite them.
REQ-030 SHALL always satisfy match_cnt + mism_cnt equal to the number of samples taken; the counters cannot wrap because their width is IN_W+1.
REQ-031 SHALL compare enc_out in full width; a golden value of OUT_W bits is zero-extended.

Reset
REQ-032 SHALL, with rst_n low, force state IDLE, busy=0, done=0, match_cnt=0, mism_cnt=0, alarm=0, first_bad_addr=0, first_bad_val=0 and trig_hit=0 asynchronously.
REQ-033 SHALL abort a sweep when reset is asserted mid-RUN and SHALL require a new start afterwards.

Configuration
REQ-034 SHALL, with CHK_TRIG_DETECT_EN defined, set trig_hit on any mismatch where (in_data & TRIG_MASK) == TRIG_VAL; trig_hit is sticky until start or reset.
REQ-035 SHALL, without CHK_TRIG_DETECT_EN, tie trig_hit to 0 and generate no trigger logic.

Structure
REQ-036 SHALL place IN_W/OUT_W defaults, the state enumeration and the golden floor-log2 function in package enc_chk_pkg.
REQ-037 SHALL place the combinational golden model in sub-module enc_golden, which the checker instantiates.

Verification
REQ-038 SHALL cover: correct sweep, in_data 0..1023 with golden enc_out -> done, match_cnt=1024, mism_cnt=0, alarm=0.
REQ-039 SHALL cover: a trojan fault where enc_out is forced to 4'd0 at in_data=11 -> mism_cnt=1, first_bad_addr=11, first_bad_val=0, alarm=1, trig_hit=1 (macro on) or 0 (macro off).
REQ-040 SHALL cover: two faults at 11 and 27 -> mism_cnt=2, first_bad_addr=11.
REQ-041 SHALL cover: in_vld low every other cycle -> done only after 1024 valid samples, and counts unchanged versus the first scenario.
REQ-042 SHALL cover: rst_n low after 300 samples -> all outputs 0 and state IDLE; a restart then completes with match_cnt=1024.
REQ-043 SHALL cover: start pulsed mid-RUN is ignored, and start in DONE clears the results and begins a new sweep.

Source files
------------

// File: rtl/enc_chk_pkg.sv
// Shared definitions for the encoder sweep checker: default widths,
// FSM state encoding and the golden floor-log2 reference function.
package enc_chk_pkg;

  localparam int IN_W_DEF  = 10;
  localparam int OUT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index of the most-significant set bit; returns 0 for an all-zero word
  // (the checker treats that input as don't-care anyway).
  function automatic logic [5:0] floor_log2(input logic [31:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/enc_golden.sv
// Combinational golden model: expected priority-encoder output for a word.
module enc_golden
  import enc_chk_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  data_i,
  output logic [OUT_W-1:0] gold_o
);

  logic [31:0] data_ext;
  logic [5:0]  idx;

  // Widen to the function's fixed width, then fit the index to OUT_W.
  always_comb begin
    data_ext = 32'(data_i);
    idx      = floor_log2(data_ext);
    gold_o   = OUT_W'(idx);
  end

endmodule

// File: rtl/enc_sweep_checker.sv
// Sweep checker for an upstream priority encoder. Compares each valid
// (in_data, enc_out) pair against the golden floor-log2 model during a
// sweep of SWEEP_LEN samples and keeps match/mismatch statistics.
// Optional trigger-pattern detection is built only when the macro
// CHK_TRIG_DETECT_EN is defined; otherwise trig_hit is tied low.
module enc_sweep_checker
  import enc_chk_pkg::*;
#(
  parameter int              IN_W      = IN_W_DEF,
  parameter int              OUT_W     = OUT_W_DEF,
  parameter int              SWEEP_LEN = 1024,
  parameter logic [IN_W-1:0] TRIG_MASK = 'hF,
  parameter logic [IN_W-1:0] TRIG_VAL  = 'hB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_vld,
  input  logic [IN_W-1:0]  in_data,
  input  logic [OUT_W-1:0] enc_out,
  output logic             busy,
  output logic             done,
  output logic [IN_W:0]    match_cnt,
  output logic [IN_W:0]    mism_cnt,
  output logic             alarm,
  output logic [IN_W-1:0]  first_bad_addr,
  output logic [OUT_W-1:0] first_bad_val,
  output logic             trig_hit
);

  localparam logic [IN_W:0] CNT_ONE  = (IN_W+1)'(1);
  localparam logic [IN_W:0] LAST_IDX = (IN_W+1)'(SWEEP_LEN - 1);

  // A trigger value with bits outside the mask could never match.
  if ((TRIG_VAL & ~TRIG_MASK) != '0) begin : g_bad_trig_cfg
    $error("enc_sweep_checker: TRIG_VAL has bits outside TRIG_MASK");
  end

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [IN_W:0]    match_cnt_q;
  logic [IN_W:0]    mism_cnt_q;
  logic             alarm_q;
  logic [IN_W-1:0]  first_bad_addr_q;
  logic [OUT_W-1:0] first_bad_val_q;

  logic [OUT_W-1:0] gold;
  logic             is_match;
  logic             sample;
  logic             start_accept;
  logic [IN_W:0]    taken;
  logic             last_sample;

  enc_golden #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_golden (
    .data_i (in_data),
    .gold_o (gold)
  );

  // Sample qualification, match decision and end-of-sweep detection.
  always_comb begin
    is_match     = (in_data == '0) || (enc_out == gold);
    sample       = (state_q == ST_RUN) && in_vld;
    start_accept = start && (state_q != ST_RUN);
    taken        = match_cnt_q + mism_cnt_q;
    last_sample  = (taken == LAST_IDX);
  end

  // Sweep FSM with registered status, counters and first-fault capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      match_cnt_q      <= '0;
      mism_cnt_q       <= '0;
      alarm_q          <= 1'b0;
      first_bad_addr_q <= '0;
      first_bad_val_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_accept) begin
            state_q          <= ST_RUN;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            match_cnt_q      <= '0;
            mism_cnt_q       <= '0;
            alarm_q          <= 1'b0;
            first_bad_addr_q <= '0;
            first_bad_val_q  <= '0;
          end
        end
        ST_RUN: begin
          if (sample) begin
            if (is_match) begin
              match_cnt_q <= match_cnt_q + CNT_ONE;
            end else begin
              mism_cnt_q <= mism_cnt_q + CNT_ONE;
              alarm_q    <= 1'b1;
              if (mism_cnt_q == '0) begin
                first_bad_addr_q <= in_data;
                first_bad_val_q  <= enc_out;
              end
            end
            if (last_sample) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHK_TRIG_DETECT_EN
  logic trig_hit_q;
  logic trig_sel;

  assign trig_sel = ((in_data & TRIG_MASK) == TRIG_VAL);

  // Sticky flag for mismatches on trigger-pattern inputs, cleared by a new sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_hit_q <= 1'b0;
    end else if (start_accept) begin
      trig_hit_q <= 1'b0;
    end else if (sample && !is_match && trig_sel) begin
      trig_hit_q <= 1'b1;
    end
  end

  assign trig_hit = trig_hit_q;
`else
  assign trig_hit = 1'b0;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign match_cnt      = match_cnt_q;
  assign mism_cnt       = mism_cnt_q;
  assign alarm          = alarm_q;
  assign first_bad_addr = first_bad_addr_q;
  assign first_bad_val  = first_bad_val_q;

endmodule

// File: tb/tb_enc_sweep_checker.sv
// Directed testbench for enc_sweep_checker: full sweeps with and without
// planted faults, gapped in_vld, ignored mid-run start, re-arm from DONE
// and asynchronous reset mid-sweep.
module tb_enc_sweep_checker;

  localparam int IN_W  = 10;
  localparam int OUT_W = 4;
  localparam int N     = 1024;

`ifdef CHK_TRIG_DETECT_EN
  localparam logic TRIG_ON = 1'b1;
`else
  localparam logic TRIG_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_vld = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic [OUT_W-1:0] enc_out = '0;
  logic             busy;
  logic             done;
  logic [IN_W:0]    match_cnt;
  logic [IN_W:0]    mism_cnt;
  logic             alarm;
  logic [IN_W-1:0]  first_bad_addr;
  logic [OUT_W-1:0] first_bad_val;
  logic             trig_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enc_sweep_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .in_vld         (in_vld),
    .in_data        (in_data),
    .enc_out        (enc_out),
    .busy           (busy),
    .done           (done),
    .match_cnt      (match_cnt),
    .mism_cnt       (mism_cnt),
    .alarm          (alarm),
    .first_bad_addr (first_bad_addr),
    .first_bad_val  (first_bad_val),
    .trig_hit       (trig_hit)
  );

  // Reference: position of highest set bit by repeated halving.
  function automatic logic [OUT_W-1:0] ref_log2(input int v);
    int r;
    r = 0;
    while (v > 1) begin
      v = v >> 1;
      r++;
    end
    return OUT_W'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed samples 0..N-1; fa/fb get enc_out forced to 0, gap inserts an
  // invalid cycle before each sample, stop_at aborts early, mid_start
  // raises start together with that sample.
  task automatic feed(input int fa, input int fb, input bit gap,
                      input int stop_at, input int mid_start);
    for (int i = 0; i < N; i++) begin
      if (i == stop_at) break;
      if (gap) begin
        in_vld  = 1'b0;
        in_data = IN_W'(11);
        enc_out = '0;
        tick();
      end
      in_vld  = 1'b1;
      in_data = IN_W'(i);
      if (i == 0) enc_out = 4'hA;
      else if (i == fa || i == fb) enc_out = '0;
      else enc_out = ref_log2(i);
      start = (i == mid_start);
      if (i == N - 1) check("done_before_last", 32'(done), 32'd0);
      tick();
      start = 1'b0;
      if (i == 0) check("zero_is_dont_care", 32'(match_cnt), 32'd1);
      if (i == fa && fa == 11) begin
        check("mism_one_cycle_later", 32'(mism_cnt), 32'd1);
        check("alarm_one_cycle_later", 32'(alarm), 32'd1);
      end
      if (i == mid_start) check("busy_after_mid_start", 32'(busy), 32'd1);
    end
    in_vld = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_match", 32'(match_cnt), 32'd0);
    check("rst_mism", 32'(mism_cnt), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_fba", 32'(first_bad_addr), 32'd0);
    check("rst_fbv", 32'(first_bad_val), 32'd0);
    check("rst_trig", 32'(trig_hit), 32'd0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: clean sweep
    pulse_start();
    check("s1_busy_start", 32'(busy), 32'd1);
    check("s1_done_start", 32'(done), 32'd0);
    feed(-1, -1, 1'b0, -1, -1);
    check("s1_done", 32'(done), 32'd1);
    check("s1_busy", 32'(busy), 32'd0);
    check("s1_match", 32'(match_cnt), 32'd1024);
    check("s1_mism", 32'(mism_cnt), 32'd0);
    check("s1_alarm", 32'(alarm), 32'd0);
    check("s1_trig", 32'(trig_hit), 32'd0);
    // Results hold in DONE despite further valid (faulty) input
    in_vld  = 1'b1;
    in_data = IN_W'(11);
    enc_out = '0;
    tick();
    tick();
    in_vld = 1'b0;
    check("s1_hold_match", 32'(match_cnt), 32'd1024);
    check("s1_hold_mism", 32'(mism_cnt), 32'd0);

    // Scenario 2: single fault at 11, started from DONE (re-arm clears)
    pulse_start();
    check("s2_rearm_match", 32'(match_cnt), 32'd0);
    check("s2_rearm_busy", 32'(busy), 32'd1);
    check("s2_rearm_done", 32'(done), 32'd0);
    feed(11, -1, 1'b0, -1, -1);
    check("s2_done", 32'(done), 32'd1);
    check("s2_mism", 32'(mism_cnt), 32'd1);
    check("s2_match", 32'(match_cnt), 32'd1023);
    check("s2_fba", 32'(first_bad_addr), 32'd11);
    check("s2_fbv", 32'(first_bad_val), 32'd0);
    check("s2_alarm", 32'(alarm), 32'd1);
    check("s2_trig", 32'(trig_hit), 32'(TRIG_ON));

    // Scenario 3: two faults, first one is kept
    pulse_start();
    check("s3_clear_mism", 32'(mism_cnt), 32'd0);
    check("s3_clear_alarm", 32'(alarm), 32'd0);
    check("s3_clear_fba", 32'(first_bad_addr), 32'd0);
    check("s3_clear_trig", 32'(trig_hit), 32'd0);
    feed(11, 27, 1'b0, -1, -1);
    check("s3_mism", 32'(mism_cnt), 32'd2);
    check("s3_match", 32'(match_cnt), 32'd1022);
    check("s3_fba", 32'(first_bad_addr), 32'd11);
    check("s3_fbv", 32'(first_bad_val), 32'd0);
    check("s3_done", 32'(done), 32'd1);

    // Scenario 4: in_vld low every other cycle, invalid cycles carry faults
    pulse_start();
    feed(-1, -1, 1'b1, -1, -1);
    check("s4_done", 32'(done), 32'd1);
    check("s4_match", 32'(match_cnt), 32'd1024);
    check("s4_mism", 32'(mism_cnt), 32'd0);
    check("s4_alarm", 32'(alarm), 32'd0);

    // Scenario 5: start mid-run is ignored
    pulse_start();
    feed(-1, -1, 1'b0, -1, 500);
    check("s5_done", 32'(done), 32'd1);
    check("s5_match", 32'(match_cnt), 32'd1024);
    check("s5_mism", 32'(mism_cnt), 32'd0);

    // Scenario 6: asynchronous reset after 300 samples, then restart
    pulse_start();
    feed(11, -1, 1'b0, 300, -1);
    check("s6_pre_match", 32'(match_cnt), 32'd299);
    check("s6_pre_mism", 32'(mism_cnt), 32'd1);
    rst_n = 1'b0;
    #2;
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_done", 32'(done), 32'd0);
    check("s6_rst_match", 32'(match_cnt), 32'd0);
    check("s6_rst_mism", 32'(mism_cnt), 32'd0);
    check("s6_rst_alarm", 32'(alarm), 32'd0);
    check("s6_rst_fba", 32'(first_bad_addr), 32'd0);
    check("s6_rst_fbv", 32'(first_bad_val), 32'd0);
    check("s6_rst_trig", 32'(trig_hit), 32'd0);
    tick();
    rst_n = 1'b1;
    // Without a new start nothing is sampled
    in_vld  = 1'b1;
    in_data = IN_W'(5);
    enc_out = 4'd2;
    for (int k = 0; k < 5; k++) tick();
    in_vld = 1'b0;
    check("s6_idle_match", 32'(match_cnt), 32'd0);
    check("s6_idle_busy", 32'(busy), 32'd0);
    pulse_start();
    feed(-1, -1, 1'b0, -1, -1);
    check("s6_restart_done", 32'(done), 32'd1);
    check("s6_restart_match", 32'(match_cnt), 32'd1024);
    check("s6_restart_mism", 32'(mism_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
